// File: rtl/sys_cmd_ctrl_if.sv
// Signal bundle between the command controller (master) and its RX, ALU, register file and TX peers (slave).
interface sys_cmd_ctrl_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_OUT_WIDTH = 16,
   parameter int FUN_WIDTH     = 4
);
   logic [DATA_WIDTH-1:0]    RX_P_DATA;
   logic                     RX_D_VLD;
   logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
   logic                     OUT_Valid;
   logic [DATA_WIDTH-1:0]    RdData;
   logic                     RdData_Valid;
   logic                     Busy;
   logic                     ALU_EN;
   logic [FUN_WIDTH-1:0]     ALU_FUN;
   logic                     CLK_EN;
   logic [ADDR_WIDTH-1:0]    Address;
   logic                     WrEn;
   logic                     RdEn;
   logic [DATA_WIDTH-1:0]    WrData;
   logic [DATA_WIDTH-1:0]    TX_P_DATA;
   logic                     TX_D_VLD;
   logic                     clk_div_en;
   logic                     frame_err;

   modport master (
      input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_Valid, RdData, RdData_Valid, Busy,
      output ALU_EN, ALU_FUN, CLK_EN, Address, WrEn, RdEn, WrData,
             TX_P_DATA, TX_D_VLD, clk_div_en, frame_err
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_Valid, RdData, RdData_Valid, Busy,
      input  ALU_EN, ALU_FUN, CLK_EN, Address, WrEn, RdEn, WrData,
             TX_P_DATA, TX_D_VLD, clk_div_en, frame_err
   );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Byte-framed command decoder driving register-file writes/reads, ALU operations and TX replies.
// Burst read (0xEE) is compiled in only when SYS_CMD_CTRL_BURST_EN is defined.
module sys_cmd_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int ALU_OUT_WIDTH  = 16,
   parameter int FUN_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic           CLK,
   input  logic           RST,
   sys_cmd_ctrl_if.master bus
);
   localparam int NBYTES = ALU_OUT_WIDTH / DATA_WIDTH;
   localparam int BCNT_W = $clog2(NBYTES + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);
`ifdef SYS_CMD_CTRL_BURST_EN
   localparam logic [DATA_WIDTH-1:0] CMD_BRD = DATA_WIDTH'(8'hEE);
`endif

   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUN,
`ifdef SYS_CMD_CTRL_BURST_EN
      GET_CNT,
`endif
      RD_REQ, RD_WAIT, ALU_WAIT, TX_LOAD, TX_HI, TX_LO
   } state_t;

   typedef enum logic [1:0] {
      OP_WR, OP_RD
`ifdef SYS_CMD_CTRL_BURST_EN
      , OP_BURST
`endif
   } op_t;

   state_t                   state_q;
   op_t                      op_q;
   logic [ADDR_WIDTH-1:0]    addr_q;
   logic [DATA_WIDTH-1:0]    wrdata_q;
   logic                     wren_q;
   logic                     rden_q;
   logic                     alu_en_q;
   logic [FUN_WIDTH-1:0]     alu_fun_q;
   logic                     clk_en_q;
   logic [DATA_WIDTH-1:0]    tx_data_q;
   logic                     tx_vld_q;
   logic                     clk_div_en_q;
   logic                     frame_err_q;
   logic [ALU_OUT_WIDTH-1:0] shift_q;
   logic [BCNT_W-1:0]        bytes_left_q;
   logic [TO_W-1:0]          to_cnt_q;
`ifdef SYS_CMD_CTRL_BURST_EN
   logic [DATA_WIDTH-1:0]    burst_left_q;
`endif

   logic in_get;
   logic to_hit;

   always_comb begin
      in_get = 1'b0;
      case (state_q)
         GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUN: in_get = 1'b1;
`ifdef SYS_CMD_CTRL_BURST_EN
         GET_CNT: in_get = 1'b1;
`endif
         default: in_get = 1'b0;
      endcase
   end

   // The counter only advances on silent GET_* cycles, so the last silent cycle trips it.
   assign to_hit = in_get && !bus.RX_D_VLD && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q      <= IDLE;
         op_q         <= OP_WR;
         addr_q       <= '0;
         wrdata_q     <= '0;
         wren_q       <= 1'b0;
         rden_q       <= 1'b0;
         alu_en_q     <= 1'b0;
         alu_fun_q    <= '0;
         clk_en_q     <= 1'b0;
         tx_data_q    <= '0;
         tx_vld_q     <= 1'b0;
         clk_div_en_q <= 1'b0;
         frame_err_q  <= 1'b0;
         shift_q      <= '0;
         bytes_left_q <= '0;
         to_cnt_q     <= '0;
`ifdef SYS_CMD_CTRL_BURST_EN
         burst_left_q <= '0;
`endif
      end else begin
         clk_div_en_q <= 1'b1;
         wren_q       <= 1'b0;
         rden_q       <= 1'b0;
         alu_en_q     <= 1'b0;
         tx_vld_q     <= 1'b0;
         frame_err_q  <= 1'b0;
         if (in_get && !bus.RX_D_VLD) to_cnt_q <= to_cnt_q + TO_W'(1);
         else                         to_cnt_q <= '0;

         if (to_hit) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
            to_cnt_q    <= '0;
         end else begin
            case (state_q)
               IDLE: if (bus.RX_D_VLD) begin
                  if (bus.RX_P_DATA == CMD_WR) begin
                     op_q <= OP_WR; state_q <= GET_ADDR;
                  end else if (bus.RX_P_DATA == CMD_RD) begin
                     op_q <= OP_RD; state_q <= GET_ADDR;
                  end else if (bus.RX_P_DATA == CMD_ALU) begin
                     state_q <= GET_OPA;
                  end else if (bus.RX_P_DATA == CMD_FUN) begin
                     state_q <= GET_FUN;
`ifdef SYS_CMD_CTRL_BURST_EN
                  end else if (bus.RX_P_DATA == CMD_BRD) begin
                     op_q <= OP_BURST; state_q <= GET_ADDR;
`endif
                  end
               end
               GET_ADDR: if (bus.RX_D_VLD) begin
                  addr_q <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                  case (op_q)
                     OP_WR: state_q <= GET_DATA;
`ifdef SYS_CMD_CTRL_BURST_EN
                     OP_BURST: state_q <= GET_CNT;
`endif
                     default: begin
`ifdef SYS_CMD_CTRL_BURST_EN
                        burst_left_q <= DATA_WIDTH'(1);
`endif
                        state_q <= RD_REQ;
                     end
                  endcase
               end
               GET_DATA: if (bus.RX_D_VLD) begin
                  wrdata_q <= bus.RX_P_DATA;
                  wren_q   <= 1'b1;
                  state_q  <= IDLE;
               end
               GET_OPA: if (bus.RX_D_VLD) begin
                  addr_q   <= ADDR_WIDTH'(0);
                  wrdata_q <= bus.RX_P_DATA;
                  wren_q   <= 1'b1;
                  state_q  <= GET_OPB;
               end
               GET_OPB: if (bus.RX_D_VLD) begin
                  addr_q   <= ADDR_WIDTH'(1);
                  wrdata_q <= bus.RX_P_DATA;
                  wren_q   <= 1'b1;
                  state_q  <= GET_FUN;
               end
               GET_FUN: if (bus.RX_D_VLD) begin
                  alu_fun_q <= bus.RX_P_DATA[FUN_WIDTH-1:0];
                  alu_en_q  <= 1'b1;
                  clk_en_q  <= 1'b1;
                  state_q   <= ALU_WAIT;
               end
`ifdef SYS_CMD_CTRL_BURST_EN
               GET_CNT: if (bus.RX_D_VLD) begin
                  burst_left_q <= (bus.RX_P_DATA == '0) ? DATA_WIDTH'(1) : bus.RX_P_DATA;
                  state_q      <= RD_REQ;
               end
`endif
               RD_REQ: begin
                  rden_q  <= 1'b1;
                  state_q <= RD_WAIT;
               end
               RD_WAIT: if (bus.RdData_Valid) begin
                  shift_q      <= ALU_OUT_WIDTH'(bus.RdData);
                  bytes_left_q <= BCNT_W'(1);
                  state_q      <= TX_LOAD;
               end
               ALU_WAIT: if (bus.OUT_Valid) begin
                  shift_q      <= bus.ALU_OUT;
                  bytes_left_q <= BCNT_W'(NBYTES);
                  clk_en_q     <= 1'b0;
                  state_q      <= TX_LOAD;
               end
               // Low byte goes out first; the shifter exposes the next byte each load.
               TX_LOAD: if (!bus.Busy) begin
                  tx_data_q    <= shift_q[DATA_WIDTH-1:0];
                  tx_vld_q     <= 1'b1;
                  shift_q      <= shift_q >> DATA_WIDTH;
                  bytes_left_q <= bytes_left_q - BCNT_W'(1);
                  state_q      <= TX_HI;
               end
               TX_HI: if (bus.Busy) state_q <= TX_LO;
               TX_LO: if (!bus.Busy) begin
                  if (bytes_left_q != '0) begin
                     state_q <= TX_LOAD;
`ifdef SYS_CMD_CTRL_BURST_EN
                  end else if (burst_left_q > DATA_WIDTH'(1)) begin
                     burst_left_q <= burst_left_q - DATA_WIDTH'(1);
                     addr_q       <= addr_q + ADDR_WIDTH'(1);
                     state_q      <= RD_REQ;
`endif
                  end else begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.ALU_EN     = alu_en_q;
   assign bus.ALU_FUN    = alu_fun_q;
   assign bus.CLK_EN     = clk_en_q;
   assign bus.Address    = addr_q;
   assign bus.WrEn       = wren_q;
   assign bus.RdEn       = rden_q;
   assign bus.WrData     = wrdata_q;
   assign bus.TX_P_DATA  = tx_data_q;
   assign bus.TX_D_VLD   = tx_vld_q;
   assign bus.clk_div_en = clk_div_en_q;
   assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl with small register-file, ALU and TX peer models.
module tb_sys_cmd_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int OW = 16;
   localparam int FW = 4;
   localparam int TO = 64;

   logic clk;
   logic rst_n;

   sys_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_OUT_WIDTH(OW), .FUN_WIDTH(FW)) bus ();

   sys_cmd_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_OUT_WIDTH(OW),
      .FUN_WIDTH(FW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   int checks_cnt = 0;
   int errors_cnt = 0;

   logic [DW-1:0] mem [0:15];
   logic [DW-1:0] tx_log [0:63];
   int            tx_n, wr_n, rd_n, fe_n, busy_viol, clk_en_bad;
   logic [AW-1:0] last_wr_addr;
   logic [DW-1:0] last_wr_data;
   logic [FW-1:0] alu_fun_seen;
   logic [OW-1:0] alu_result;
   logic          busy_force;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Peer models: everything sampled and driven on the falling edge.
   initial begin
      int alu_cnt;
      int busy_cnt;
      alu_cnt = 0; busy_cnt = 0;
      tx_n = 0; wr_n = 0; rd_n = 0; fe_n = 0; busy_viol = 0; clk_en_bad = 0;
      last_wr_addr = '0; last_wr_data = '0; alu_fun_seen = '0;
      bus.ALU_OUT = '0; bus.OUT_Valid = 1'b0;
      bus.RdData = '0; bus.RdData_Valid = 1'b0; bus.Busy = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = DW'(8'hA0 + i);
      mem[2] = 8'h7E;
      forever begin
         @(negedge clk);
         bus.RdData_Valid = 1'b0;
         if (bus.RdEn) begin
            bus.RdData       = mem[bus.Address];
            bus.RdData_Valid = 1'b1;
            rd_n++;
         end
         if (bus.WrEn) begin
            mem[bus.Address] = bus.WrData;
            last_wr_addr     = bus.Address;
            last_wr_data     = bus.WrData;
            wr_n++;
         end
         bus.OUT_Valid = 1'b0;
         if (bus.ALU_EN) begin
            alu_cnt      = 3;
            alu_fun_seen = bus.ALU_FUN;
         end else if (alu_cnt != 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
               bus.OUT_Valid = 1'b1;
               bus.ALU_OUT   = alu_result;
               if (!bus.CLK_EN) clk_en_bad++;
            end
         end
         if (bus.frame_err) fe_n++;
         if (bus.TX_D_VLD) begin
            if (bus.Busy) busy_viol++;
            if (tx_n < 64) tx_log[tx_n] = bus.TX_P_DATA;
            tx_n++;
            busy_cnt = 4;
         end else if (busy_cnt != 0) begin
            busy_cnt--;
         end
         bus.Busy = busy_force || (busy_cnt != 0);
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.RX_P_DATA = b;
      bus.RX_D_VLD  = 1'b1;
      @(negedge clk);
      bus.RX_D_VLD  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int exp_tx, exp_rd, base_tx, base_wr;
      bit seen;
      rst_n = 1'b0;
      busy_force = 1'b0;
      alu_result = '0;
      bus.RX_P_DATA = '0;
      bus.RX_D_VLD  = 1'b0;

      idle(3);
      chk("rst_wren",   32'(bus.WrEn), 0);
      chk("rst_rden",   32'(bus.RdEn), 0);
      chk("rst_alu_en", 32'(bus.ALU_EN), 0);
      chk("rst_clk_en", 32'(bus.CLK_EN), 0);
      chk("rst_tx_vld", 32'(bus.TX_D_VLD), 0);
      chk("rst_frerr",  32'(bus.frame_err), 0);
      chk("rst_divEn",  32'(bus.clk_div_en), 0);
      chk("rst_addr",   32'(bus.Address), 0);
      chk("rst_txdata", 32'(bus.TX_P_DATA), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("divEn_on", 32'(bus.clk_div_en), 1);

      send(8'hAA); send(8'h05); send(8'h3C); idle(10);
      $display("frame AA 05 3C: wr=%0d addr=%0h data=%0h tx=%0d", wr_n, last_wr_addr, last_wr_data, tx_n);
      chk("wr_count",  32'(wr_n), 1);
      chk("wr_addr",   32'(last_wr_addr), 5);
      chk("wr_data",   32'(last_wr_data), 32'h3C);
      chk("wr_no_tx",  32'(tx_n), 0);

      alu_result = 16'h0030;
      send(8'hCC); send(8'h10); send(8'h20); send(8'h00); idle(40);
      $display("frame CC 10 20 00: wr=%0d tx=%0d", wr_n, tx_n);
      chk("opa_reg0",   32'(mem[0]), 32'h10);
      chk("opb_reg1",   32'(mem[1]), 32'h20);
      chk("cc_wr_cnt",  32'(wr_n), 3);
      chk("cc_tx_cnt",  32'(tx_n), 2);
      chk("cc_tx_lsb",  32'(tx_log[0]), 32'h30);
      chk("cc_tx_msb",  32'(tx_log[1]), 32'h00);
      chk("cc_fun",     32'(alu_fun_seen), 0);
      chk("cc_clk_en",  32'(clk_en_bad), 0);
      chk("cc_clk_off", 32'(bus.CLK_EN), 0);

      alu_result = 16'hBEEF;
      send(8'hDD); send(8'h0A); idle(40);
      $display("frame DD 0A: tx=%0d", tx_n);
      chk("dd_tx_cnt", 32'(tx_n), 4);
      chk("dd_tx_lsb", 32'(tx_log[2]), 32'hEF);
      chk("dd_tx_msb", 32'(tx_log[3]), 32'hBE);
      chk("dd_fun",    32'(alu_fun_seen), 32'hA);

      busy_force = 1'b1;
      send(8'hBB); send(8'h02); idle(20);
      chk("rd_held_tx", 32'(tx_n), 4);
      chk("rd_count",   32'(rd_n), 1);
      busy_force = 1'b0;
      idle(20);
      $display("frame BB 02: rd=%0d tx=%0d", rd_n, tx_n);
      chk("rd_tx_cnt",  32'(tx_n), 5);
      chk("rd_tx_data", 32'(tx_log[4]), 32'h7E);
      chk("rd_once",    32'(rd_n), 1);
      chk("busy_viol",  32'(busy_viol), 0);

      send(8'hAA); send(8'h05); idle(TO - 5);
      chk("to_early", 32'(fe_n), 0);
      idle(15);
      $display("frame AA 05 timeout: frame_err=%0d wr=%0d", fe_n, wr_n);
      chk("to_pulse", 32'(fe_n), 1);
      chk("to_no_wr", 32'(wr_n), 3);
      send(8'hBB); send(8'h05); idle(30);
      chk("to_next_tx",   32'(tx_n), 6);
      chk("to_next_data", 32'(tx_log[5]), 32'h3C);

      send(8'h55); send(8'hBB); send(8'h01); idle(30);
      $display("frame 55 BB 01: tx=%0d", tx_n);
      chk("unk_tx_cnt",  32'(tx_n), 7);
      chk("unk_tx_data", 32'(tx_log[6]), 32'h20);

      send(8'hEE); send(8'h0E); send(8'h03); idle(80);
      $display("frame EE 0E 03: rd=%0d tx=%0d", rd_n, tx_n);
`ifdef SYS_CMD_CTRL_BURST_EN
      chk("brst_rd",  32'(rd_n), 6);
      chk("brst_tx",  32'(tx_n), 10);
      chk("brst_b0",  32'(tx_log[7]), 32'hAE);
      chk("brst_b1",  32'(tx_log[8]), 32'hAF);
      chk("brst_b2",  32'(tx_log[9]), 32'h10);
      send(8'hEE); send(8'h03); send(8'h00); idle(40);
      $display("frame EE 03 00: rd=%0d tx=%0d", rd_n, tx_n);
      exp_rd = 7; exp_tx = 11;
      chk("brst0_tx_data", 32'(tx_log[10]), 32'hA3);
`else
      exp_rd = 3; exp_tx = 7;
`endif
      chk("brst_rd_total", 32'(rd_n), 32'(exp_rd));
      chk("brst_tx_total", 32'(tx_n), 32'(exp_tx));

      send(8'hBB); send(8'h02);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (bus.TX_D_VLD) seen = 1'b1;
      end
      chk("txhi_seen", 32'(seen), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_txvld", 32'(bus.TX_D_VLD), 0);
      chk("mid_rst_rden",  32'(bus.RdEn), 0);
      chk("mid_rst_txdat", 32'(bus.TX_P_DATA), 0);
      chk("mid_rst_divEn", 32'(bus.clk_div_en), 0);
      chk("mid_rst_addr",  32'(bus.Address), 0);
      idle(2);
      base_tx = tx_n;
      rst_n = 1'b1;
      idle(15);
      chk("post_rst_quiet", 32'(tx_n), 32'(base_tx));
      base_wr = wr_n;
      send(8'hAA); send(8'h07); send(8'h99); idle(10);
      $display("frame AA 07 99 after reset: wr=%0d", wr_n);
      chk("post_rst_wr",   32'(wr_n), 32'(base_wr + 1));
      chk("post_rst_data", 32'(mem[7]), 32'h99);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
